// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack speculative controller.
package ras_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_RAS_DEPTH = 16;
  localparam int DEF_LOG_DEPTH = 8;

  // Kind of stack operation recorded in the undo log.
  typedef enum logic {
    RAS_PUSH = 1'b0,
    RAS_POP  = 1'b1
  } ras_op_e;

  // One undo-log record; data is the popped value for POP entries.
  typedef struct packed {
    ras_op_e                op;
    logic [DEF_WIDTH-1:0]   data;
  } ras_log_entry_t;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UNWIND = 2'd2
  } ras_state_e;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // x1 (ra) and x5 (t0) are the RISC-V link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_ctrl_chk.sv
// Invariant checks for the RAS controller.
module ras_ctrl_chk #(
  parameter int RAS_DEPTH = 16,
  parameter int OCC_W     = 5
) (
  input logic             i_clk,
  input logic             i_rst,
  input logic             i_unwind,
  input logic             i_commit,
  input logic             i_lifo_push,
  input logic             i_lifo_pop,
  input logic [OCC_W-1:0] i_occ
);

  a_push_pop_excl: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_lifo_push && i_lifo_pop));

  // A retirement while squashed ops are being undone means the pipeline is broken.
  a_no_commit_in_unwind: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_unwind && i_commit));

  a_occ_range: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_occ <= OCC_W'(RAS_DEPTH)));

endmodule

// File: rtl/ras_undo_log.sv
// Circular undo log of uncommitted RAS operations.
// New entries enter at head; commit retires at tail; unwind removes head-1.
module ras_undo_log
  import ras_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOG_DEPTH = DEF_LOG_DEPTH,
  localparam int PTR_W    = $clog2(LOG_DEPTH),
  localparam int CNT_W    = $clog2(LOG_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push_new,
  input  ras_op_e          i_new_op,
  input  logic [WIDTH-1:0] i_new_data,
  input  logic             i_pop_newest,
  input  logic             i_pop_oldest,
  output ras_op_e          o_newest_op,
  output logic [WIDTH-1:0] o_newest_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  ras_op_e          r_op   [LOG_DEPTH];
  logic [WIDTH-1:0] r_data [LOG_DEPTH];

  logic             w_do_push;
  logic             w_do_newest;
  logic             w_do_oldest;
  logic [PTR_W-1:0] w_newest_idx;

  // Qualify requests against occupancy; removals from both ends never coincide.
  always_comb begin
    o_full       = (r_count == CNT_W'(LOG_DEPTH));
    o_empty      = (r_count == {CNT_W{1'b0}});
    w_newest_idx = r_head - PTR_W'(1);
    w_do_push    = i_push_new & ~o_full;
    w_do_newest  = i_pop_newest & ~o_empty;
    w_do_oldest  = i_pop_oldest & ~o_empty & ~i_pop_newest;
    o_count      = r_count;
    o_newest_op  = r_op[w_newest_idx];
    o_newest_data = r_data[w_newest_idx];
  end

  // Pointer, count and entry storage update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      for (int i = 0; i < LOG_DEPTH; i++) begin
        r_op[i]   <= RAS_PUSH;
        r_data[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_do_push) begin
        r_op[r_head]   <= i_new_op;
        r_data[r_head] <= i_new_data;
        r_head         <= r_head + PTR_W'(1);
      end else if (w_do_newest) begin
        r_head <= w_newest_idx;
      end
      if (w_do_oldest) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_newest) - CNT_W'(w_do_oldest);
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// Speculative return-address-stack controller: decodes calls/returns,
// drives the external lifo and unwinds uncommitted operations on flush.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_if_valid,
  input  logic [WIDTH-1:0] i_if_pc,
  input  logic [31:0]      i_if_instr,
  output logic             o_pred_valid,
  output logic [WIDTH-1:0] o_pred_target,
  output logic             o_ras_stall,
  input  logic             i_commit,
  input  logic             i_flush,
  output logic             o_lifo_push,
  output logic             o_lifo_pop,
  output logic [WIDTH-1:0] o_lifo_datain,
  input  logic [WIDTH-1:0] i_lifo_peek
);

  localparam int OCC_W  = $clog2(RAS_DEPTH + 1);
  localparam int CLR_W  = $clog2(RAS_DEPTH);
  localparam int LCNT_W = $clog2(LOG_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RAS_DEPTH);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RAS_DEPTH - 1);

  ras_state_e        r_state;
  ras_state_e        w_state_nxt;
  logic [OCC_W-1:0]  r_occ;
  logic [OCC_W-1:0]  w_occ_nxt;
  logic [CLR_W-1:0]  r_clr_cnt;
  logic [CLR_W-1:0]  w_clr_cnt_nxt;

  logic [6:0]        w_opcode;
  logic [4:0]        w_rd;
  logic [4:0]        w_rs1;
  logic              w_is_call;
  logic              w_is_ret;
  logic              w_fetch_go;
  logic              w_unused_instr;

  logic              w_log_push;
  ras_op_e           w_log_op;
  logic [WIDTH-1:0]  w_log_data;
  logic              w_log_pop_newest;
  logic              w_log_pop_oldest;
  ras_op_e           w_log_newest_op;
  logic [WIDTH-1:0]  w_log_newest_data;
  logic [LCNT_W-1:0] w_log_count;
  logic              w_log_full;
  logic              w_log_empty;

  assign w_unused_instr = ^{i_if_instr[31:20], i_if_instr[14:12]};

  // Classify the fetched instruction; a JALR linking through rd is a call even if rs1 links too.
  always_comb begin
    w_opcode  = i_if_instr[6:0];
    w_rd      = i_if_instr[11:7];
    w_rs1     = i_if_instr[19:15];
    w_is_call = ((w_opcode == OP_JAL) || (w_opcode == OP_JALR)) && is_link(w_rd);
    w_is_ret  = (w_opcode == OP_JALR) && !is_link(w_rd) && is_link(w_rs1);
    w_fetch_go = i_if_valid & ~w_log_full & ~i_flush;
  end

  // Next-state, occupancy, lifo drive and log requests.
  always_comb begin
    w_state_nxt      = r_state;
    w_occ_nxt        = r_occ;
    w_clr_cnt_nxt    = r_clr_cnt;
    o_pred_valid     = 1'b0;
    o_pred_target    = {WIDTH{1'b0}};
    o_ras_stall      = 1'b1;
    o_lifo_push      = 1'b0;
    o_lifo_pop       = 1'b0;
    o_lifo_datain    = {WIDTH{1'b0}};
    w_log_push       = 1'b0;
    w_log_op         = RAS_PUSH;
    w_log_data       = {WIDTH{1'b0}};
    w_log_pop_newest = 1'b0;
    w_log_pop_oldest = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // Drain the lifo blind; it ignores pops once empty.
        o_lifo_pop = 1'b1;
        w_occ_nxt  = {OCC_W{1'b0}};
        if (r_clr_cnt == CLR_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_clr_cnt_nxt = {CLR_W{1'b0}};
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + CLR_W'(1);
        end
      end
      ST_IDLE: begin
        o_ras_stall      = w_log_full;
        w_log_pop_oldest = i_commit & ~w_log_empty;
        if (i_flush) begin
          // Commit is applied first; nothing left to undo means stay put.
          if (w_log_empty) begin
            w_state_nxt = ST_IDLE;
          end else if (w_log_pop_oldest && (w_log_count == LCNT_W'(1))) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_UNWIND;
          end
        end else if (w_fetch_go && w_is_call) begin
          if (r_occ != OCC_FULL) begin
            o_lifo_push   = 1'b1;
            o_lifo_datain = i_if_pc + WIDTH'(4);
            w_log_push    = 1'b1;
            w_log_op      = RAS_PUSH;
            w_log_data    = i_if_pc + WIDTH'(4);
            w_occ_nxt     = r_occ + OCC_W'(1);
          end else begin
            w_occ_nxt = r_occ;
          end
        end else if (w_fetch_go && w_is_ret) begin
          if (r_occ != {OCC_W{1'b0}}) begin
            o_pred_valid  = 1'b1;
            o_pred_target = i_lifo_peek;
            o_lifo_pop    = 1'b1;
            w_log_push    = 1'b1;
            w_log_op      = RAS_POP;
            w_log_data    = i_lifo_peek;
            w_occ_nxt     = r_occ - OCC_W'(1);
          end else begin
            w_occ_nxt = r_occ;
          end
        end else begin
          w_occ_nxt = r_occ;
        end
      end
      ST_UNWIND: begin
        if (w_log_empty) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_log_pop_newest = 1'b1;
          if (w_log_newest_op == RAS_PUSH) begin
            o_lifo_pop = 1'b1;
            w_occ_nxt  = r_occ - OCC_W'(1);
          end else begin
            o_lifo_push   = 1'b1;
            o_lifo_datain = w_log_newest_data;
            w_occ_nxt     = r_occ + OCC_W'(1);
          end
          if (w_log_count == LCNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_UNWIND;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = {CLR_W{1'b0}};
        w_occ_nxt     = {OCC_W{1'b0}};
      end
    endcase
  end

  // State, occupancy and clear-counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_occ     <= {OCC_W{1'b0}};
      r_clr_cnt <= {CLR_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_occ     <= w_occ_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  ras_undo_log #(
    .WIDTH     (WIDTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_log (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_push_new    (w_log_push),
    .i_new_op      (w_log_op),
    .i_new_data    (w_log_data),
    .i_pop_newest  (w_log_pop_newest),
    .i_pop_oldest  (w_log_pop_oldest),
    .o_newest_op   (w_log_newest_op),
    .o_newest_data (w_log_newest_data),
    .o_count       (w_log_count),
    .o_full        (w_log_full),
    .o_empty       (w_log_empty)
  );

  ras_ctrl_chk #(
    .RAS_DEPTH (RAS_DEPTH),
    .OCC_W     (OCC_W)
  ) u_chk (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_unwind    (r_state == ST_UNWIND),
    .i_commit    (i_commit),
    .i_lifo_push (o_lifo_push),
    .i_lifo_pop  (o_lifo_pop),
    .i_occ       (r_occ)
  );

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: external lifo model plus a queue-based reference of the
// speculative stack and undo log; directed scenarios then random traffic.
module tb_ras_ctrl;
  import ras_pkg::*;

  localparam int RD = 16;
  localparam int LD = 8;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0, i_if_valid = 1'b0, i_commit = 1'b0, i_flush = 1'b0;
  logic [31:0] i_if_pc = 32'd0, i_if_instr = 32'd0, i_lifo_peek = 32'd0;
  logic        o_pred_valid, o_ras_stall, o_lifo_push, o_lifo_pop;
  logic [31:0] o_pred_target, o_lifo_datain;

  always #5 clk = ~clk;

  ras_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_if_valid(i_if_valid), .i_if_pc(i_if_pc),
    .i_if_instr(i_if_instr), .o_pred_valid(o_pred_valid), .o_pred_target(o_pred_target),
    .o_ras_stall(o_ras_stall), .i_commit(i_commit), .i_flush(i_flush),
    .o_lifo_push(o_lifo_push), .o_lifo_pop(o_lifo_pop), .o_lifo_datain(o_lifo_datain),
    .i_lifo_peek(i_lifo_peek)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0]    lifo_q[$];
  logic [31:0]    m_stk[$];
  ras_log_entry_t m_log[$];
  int             m_clear_left = 0;
  bit             m_unwinding = 1'b0;
  bit             m_known = 1'b0;

  logic        obs_push, obs_pop, obs_pv, obs_stall;
  logic [31:0] obs_tgt, obs_din;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit lnk(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // 0 = plain, 1 = call, 2 = return
  function automatic int classify(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if ((op == 7'b1101111 || op == 7'b1100111) && lnk(ins[11:7])) return 1;
    if (op == 7'b1100111 && lnk(ins[19:15])) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] jal(input logic [4:0] rd);
    return {20'h0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  // One clock: drive inputs, check outputs against the reference, advance lifo and model.
  task automatic cycle(input bit rst, input bit v, input logic [31:0] pc,
                       input logic [31:0] ins, input bit cm, input bit fl);
    bit e_stall, e_push, e_pop, e_pv;
    logic [31:0] e_din, e_tgt;
    int kind;
    ras_log_entry_t ent;
    @(negedge clk);
    i_rst = rst; i_if_valid = v; i_if_pc = pc; i_if_instr = ins; i_commit = cm; i_flush = fl;
    #1;
    obs_push = o_lifo_push; obs_pop = o_lifo_pop; obs_pv = o_pred_valid;
    obs_stall = o_ras_stall; obs_tgt = o_pred_target; obs_din = o_lifo_datain;
    e_stall = 1'b1; e_push = 1'b0; e_pop = 1'b0; e_pv = 1'b0; e_din = 32'd0; e_tgt = 32'd0;
    if (rst) begin
      m_known = 1'b1; m_clear_left = RD; m_unwinding = 1'b0;
      m_stk.delete(); m_log.delete();
    end else if (m_known) begin
      if (m_clear_left > 0) begin
        e_pop = 1'b1;
        m_clear_left--;
      end else if (m_unwinding) begin
        ent = m_log.pop_back();
        if (ent.op == RAS_PUSH) begin
          e_pop = 1'b1;
          void'(m_stk.pop_back());
        end else begin
          e_push = 1'b1; e_din = ent.data;
          m_stk.push_back(ent.data);
        end
        if (m_log.size() == 0) m_unwinding = 1'b0;
      end else begin
        e_stall = (m_log.size() == LD);
        kind = classify(ins);
        if (cm && m_log.size() > 0) void'(m_log.pop_front());
        if (fl) begin
          m_unwinding = (m_log.size() > 0);
        end else if (v && !e_stall) begin
          if (kind == 1 && m_stk.size() < RD) begin
            e_push = 1'b1; e_din = pc + 32'd4;
            m_stk.push_back(pc + 32'd4);
            ent.op = RAS_PUSH; ent.data = pc + 32'd4;
            m_log.push_back(ent);
          end else if (kind == 2 && m_stk.size() > 0) begin
            e_pv = 1'b1; e_pop = 1'b1; e_tgt = m_stk[$];
            ent.op = RAS_POP; ent.data = m_stk[$];
            m_log.push_back(ent);
            void'(m_stk.pop_back());
          end
        end
      end
      check_val("ras_stall", {31'd0, obs_stall}, {31'd0, e_stall});
      check_val("lifo_push", {31'd0, obs_push}, {31'd0, e_push});
      check_val("lifo_pop", {31'd0, obs_pop}, {31'd0, e_pop});
      check_val("lifo_datain", obs_din, e_din);
      check_val("pred_valid", {31'd0, obs_pv}, {31'd0, e_pv});
      check_val("pred_target", obs_tgt, e_tgt);
    end
    @(posedge clk);
    #1;
    if (obs_push) begin
      if (lifo_q.size() < RD) lifo_q.push_back(obs_din);
    end else if (obs_pop) begin
      if (lifo_q.size() > 0) void'(lifo_q.pop_back());
    end
    i_lifo_peek = (lifo_q.size() > 0) ? lifo_q[$] : 32'd0;
  endtask

  task automatic idle(input bit cm, input bit fl);
    cycle(1'b0, 1'b0, 32'd0, 32'h0000_0013, cm, fl);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'd0, 32'h0000_0013, 1'b0, 1'b0);
    for (int i = 0; i < RD; i++) idle(1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] rd, rs;
    logic [31:0] ins, pc;
    bit v, cm, fl, rs_b;

    // 1: reset then sixteen draining cycles, then idle
    cycle(1'b1, 1'b0, 32'd0, 32'h13, 1'b0, 1'b0);
    for (int i = 0; i < RD; i++) begin
      idle(1'b0, 1'b0);
      check_val("clr_stall", {31'd0, obs_stall}, 32'd1);
      check_val("clr_pop", {31'd0, obs_pop}, 32'd1);
    end
    idle(1'b0, 1'b0);
    check_val("idle_stall", {31'd0, obs_stall}, 32'd0);
    check_val("idle_pop", {31'd0, obs_pop}, 32'd0);

    // 2: call then return
    cycle(1'b0, 1'b1, 32'h100, jal(5'd1), 1'b0, 1'b0);
    check_val("t2_din", obs_din, 32'h104);
    cycle(1'b0, 1'b1, 32'h180, jalr(5'd0, 5'd1), 1'b0, 1'b0);
    check_val("t2_pv", {31'd0, obs_pv}, 32'd1);
    check_val("t2_tgt", obs_tgt, 32'h104);

    // 3: overflow drop, then drain with returns
    do_reset();
    for (int i = 0; i <= RD; i++) begin
      cycle(1'b0, 1'b1, 32'(i * 16), jal(5'd1), 1'b0, 1'b0);
      if (i == RD) check_val("t3_drop", {31'd0, obs_push}, 32'd0);
      idle(1'b1, 1'b0);
    end
    for (int k = 0; k < RD; k++) begin
      cycle(1'b0, 1'b1, 32'h400, jalr(5'd0, 5'd5), 1'b0, 1'b0);
      check_val("t3_tgt", obs_tgt, 32'hF4 - 32'(16 * k));
      idle(1'b1, 1'b0);
    end
    cycle(1'b0, 1'b1, 32'h400, jalr(5'd0, 5'd1), 1'b0, 1'b0);
    check_val("t3_empty_pv", {31'd0, obs_pv}, 32'd0);

    // 4: flush unwinds an uncommitted call and return
    do_reset();
    cycle(1'b0, 1'b1, 32'h200, jal(5'd1), 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h300, jalr(5'd1, 5'd2), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h340, jalr(5'd0, 5'd1), 1'b0, 1'b0);
    check_val("t4_ret", obs_tgt, 32'h304);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    check_val("t4_uw1_push", {31'd0, obs_push}, 32'd1);
    check_val("t4_uw1_din", obs_din, 32'h304);
    idle(1'b0, 1'b0);
    check_val("t4_uw2_pop", {31'd0, obs_pop}, 32'd1);
    cycle(1'b0, 1'b1, 32'h500, jalr(5'd0, 5'd1), 1'b0, 1'b0);
    check_val("t4_tgt", obs_tgt, 32'h204);

    // 5: full log stalls fetch until a commit
    do_reset();
    for (int i = 0; i < LD; i++) cycle(1'b0, 1'b1, 32'(32'h1000 + i * 8), jal(5'd5), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h2000, jal(5'd1), 1'b0, 1'b0);
    check_val("t5_stall", {31'd0, obs_stall}, 32'd1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    check_val("t5_unstall", {31'd0, obs_stall}, 32'd0);

    // 6: flush + commit + call in one cycle
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'(32'h3000 + i * 4), jal(5'd1), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h3100, jal(5'd1), 1'b1, 1'b1);
    check_val("t6_nopush", {31'd0, obs_push}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      idle(1'b0, 1'b0);
      check_val("t6_uw_pop", {31'd0, obs_pop}, 32'd1);
    end
    idle(1'b0, 1'b0);
    check_val("t6_done", {31'd0, obs_stall}, 32'd0);

    // 7: return on empty stack leaves log untouched
    do_reset();
    cycle(1'b0, 1'b1, 32'h600, jalr(5'd0, 5'd1), 1'b0, 1'b0);
    check_val("t7_pv", {31'd0, obs_pv}, 32'd0);
    check_val("t7_pop", {31'd0, obs_pop}, 32'd0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    check_val("t7_no_unwind", {31'd0, obs_stall}, 32'd0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      rd = ($urandom_range(0, 1) == 0) ? 5'd1 : 5'd5;
      rs = 5'($urandom_range(0, 31));
      if (rs == 5'd1 || rs == 5'd5) rs = 5'd0;
      case ($urandom_range(0, 7))
        0, 1:    ins = jal(rd);
        2:       ins = jalr(rd, rs);
        3, 4:    ins = jalr(rs, rd);
        5:       ins = jalr(rd, (rd == 5'd1) ? 5'd5 : 5'd1);
        6:       ins = jal(rs);
        default: ins = {$urandom()} & 32'hFFFF_FF80 | 32'h13;
      endcase
      pc   = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC : ({$urandom()} & 32'hFFFF_FFFC);
      v    = ($urandom_range(0, 3) != 0);
      cm   = !m_unwinding && ($urandom_range(0, 2) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      rs_b = ($urandom_range(0, 499) == 0);
      cycle(rs_b, v, pc, ins, cm, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
